// File: rtl/multiplicand_sequencer_if.sv
// Multiplicand sequencer bus: order request, status and gates.
// Ports: start/order in; busy/done/digit, Main Control and tank gates out.
interface multiplicand_sequencer_if #(
  parameter int CW = 6
);
  logic          start;
  logic [4:0]    order;
  logic          busy;
  logic          done;
  logic [CW-1:0] digit;
  logic          g12;
  logic          g13;
  logic          c1;
  logic          c21;
  logic          g2_pos;
  logic          g2_neg;
  logic          g3_pos;
  logic          g6_pos;
  logic          g11_neg;
  logic          da_m;

  modport master (
    output start, order,
    input  busy, done, digit,
    input  g12, g13, c1, c21,
    input  g2_pos, g2_neg, g3_pos,
    input  g6_pos, g11_neg, da_m
  );

  modport slave (
    input  start, order,
    output busy, done, digit,
    output g12, g13, c1, c21,
    output g2_pos, g2_neg, g3_pos,
    output g6_pos, g11_neg, da_m
  );
endinterface

// File: rtl/multiplicand_sequencer.sv
// Word-timed gate generator for the Multiplicand Tank and Main Control.
// Ports: clk, rst_n, bus (slave); step when MCAND_SINGLE_STEP_EN.
module multiplicand_sequencer #(
  parameter int WORD_LEN   = 36,
  parameter int MULT_WORDS = 17,
  parameter int CW         = 6
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MCAND_SINGLE_STEP_EN
  input  logic step,
`endif
  multiplicand_sequencer_if.slave bus
);

  localparam int WW = $clog2(MULT_WORDS + 1);
  localparam logic [CW-1:0] LAST_D = CW'(WORD_LEN - 1);

`ifdef MCAND_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    IDLE, STAGE1, STAGE2, EXEC, HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, STAGE1, STAGE2, EXEC
  } state_t;
`endif

  state_t        st_q, st_n;
  logic [CW-1:0] digit_q, dig_n;
  logic [WW-1:0] word_q, word_n, lastw;
  logic [4:0]    ord_q, ord_n;
  logic          pend_q, pend_n;
  logic          wrap, accept;
  logic          sh_n, mu_n, o_n;
  logic          busy_n, done_n;
  logic          g12_n, g13_n;
  logic          c1_n, c21_n;
  logic          g2_n, g3_n, g6_n;
  logic          g11_n, da_n;
`ifdef MCAND_SINGLE_STEP_EN
  logic          step_q, step_n;
`endif

  always_comb begin
    wrap   = (digit_q == LAST_D);
    dig_n  = wrap ? '0 : digit_q + 1'b1;
    accept = bus.start && (st_q == IDLE)
             && !pend_q;
    ord_n  = accept ? bus.order : ord_q;
    sh_n   = ord_n inside {5'd28, 5'd12, 5'd30};
    mu_n   = ord_n inside {5'd31, 5'd22};
    o_n    = (ord_n == 5'd9);
    lastw  = mu_n ? WW'(MULT_WORDS - 1) : '0;
    st_n   = st_q;
    pend_n = pend_q || accept;
    word_n = word_q;
`ifdef MCAND_SINGLE_STEP_EN
    step_n = (st_q == HOLD) && !wrap
             && (step_q || step);
`endif
    if (wrap) begin
      unique case (st_q)
        IDLE: begin
          if (pend_q || accept) begin
            st_n   = STAGE1;
            pend_n = 1'b0;
          end
        end
        STAGE1: st_n = STAGE2;
        STAGE2: begin
          st_n   = EXEC;
          word_n = '0;
        end
        EXEC: begin
          if (word_q == lastw) begin
`ifdef MCAND_SINGLE_STEP_EN
            st_n = HOLD;
`else
            st_n = IDLE;
`endif
          end else begin
            word_n = word_q + 1'b1;
          end
        end
`ifdef MCAND_SINGLE_STEP_EN
        HOLD: if (step_q || step) st_n = IDLE;
`endif
        default: st_n = IDLE;
      endcase
    end
  end

  // Gates are decoded from the next-cycle state and digit so the
  // registered outputs line up with digit 0 of each word.
  always_comb begin
    busy_n = pend_n || (st_n != IDLE);
    g12_n  = (st_n == STAGE1);
    g13_n  = (st_n == STAGE2);
    c1_n   = 1'b0;
    c21_n  = 1'b0;
    g2_n   = 1'b0;
    g3_n   = 1'b0;
    g6_n   = 1'b0;
    da_n   = 1'b0;
    done_n = 1'b0;
    g11_n  = 1'b1;
    unique case (1'b1)
      (st_n == STAGE1): g11_n = 1'b0;
      (st_n == STAGE2): begin
        c1_n  = sh_n || mu_n;
        c21_n = o_n;
        g11_n = sh_n || mu_n || o_n;
      end
      (st_n == EXEC): begin
        c1_n   = sh_n || mu_n;
        c21_n  = o_n;
        g6_n   = sh_n;
        g3_n   = mu_n;
        g2_n   = mu_n && (word_n == '0)
                 && (dig_n != LAST_D);
        da_n   = mu_n && (word_n == '0)
                 && (dig_n == LAST_D);
        done_n = (word_n == lastw)
                 && (dig_n == LAST_D);
      end
      default: g11_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      digit_q     <= '0;
      word_q      <= '0;
      ord_q       <= '0;
      pend_q      <= 1'b0;
`ifdef MCAND_SINGLE_STEP_EN
      step_q      <= 1'b0;
`endif
      bus.digit   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.g12     <= 1'b0;
      bus.g13     <= 1'b0;
      bus.c1      <= 1'b0;
      bus.c21     <= 1'b0;
      bus.g2_pos  <= 1'b0;
      bus.g3_pos  <= 1'b0;
      bus.g6_pos  <= 1'b0;
      bus.g11_neg <= 1'b0;
      bus.da_m    <= 1'b0;
    end else begin
      st_q        <= st_n;
      digit_q     <= dig_n;
      word_q      <= word_n;
      ord_q       <= ord_n;
      pend_q      <= pend_n;
`ifdef MCAND_SINGLE_STEP_EN
      step_q      <= step_n;
`endif
      bus.digit   <= dig_n;
      bus.busy    <= busy_n;
      bus.done    <= done_n;
      bus.g12     <= g12_n;
      bus.g13     <= g13_n;
      bus.c1      <= c1_n;
      bus.c21     <= c21_n;
      bus.g2_pos  <= g2_n;
      bus.g3_pos  <= g3_n;
      bus.g6_pos  <= g6_n;
      bus.g11_neg <= g11_n;
      bus.da_m    <= da_n;
    end
  end

  assign bus.g2_neg = ~bus.g2_pos;

endmodule

// File: tb/tb_multiplicand_sequencer.sv
// Directed bench for multiplicand_sequencer.
// Runs A, V, L, O orders, start boundary cases and mid-order reset.
module tb_multiplicand_sequencer;
  localparam int WL = 36;
  localparam int MW = 17;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef MCAND_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  always #5 clk = ~clk;

  multiplicand_sequencer_if #(.CW(CW)) bus ();

  multiplicand_sequencer #(
    .WORD_LEN  (WL),
    .MULT_WORDS(MW),
    .CW        (CW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef MCAND_SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int n_g12, n_g13, n_c1, n_c21, n_g2;
  int n_g3, n_g6, n_da, n_done, n_g11lo;
  int first_g12, done_dig, da_dig, g2_last;
  int after_busy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic wait_digit(input int d);
    int n;
    n = 0;
    while (int'(bus.digit) != d && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag,
                     input int d,
                     input logic [4:0] o,
                     input bit second);
    bit saw_done;
    bit sent2;
    n_g12 = 0; n_g13 = 0; n_c1 = 0;
    n_c21 = 0; n_g2 = 0; n_g3 = 0;
    n_g6 = 0; n_da = 0; n_done = 0;
    n_g11lo = 0;
    first_g12 = -1; done_dig = -1;
    da_dig = -1; g2_last = -1;
    after_busy = -1;
    saw_done = 0;
    sent2 = 0;
    wait_digit(d);
    chk({tag, "_sync"}, bus.digit, d);
    bus.start = 1'b1;
    bus.order = o;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_up"}, bus.busy, 1);
    for (int i = 0; i < 2000; i++) begin
      if (bus.g12) begin
        n_g12++;
        if (first_g12 < 0) first_g12 = i;
      end
      if (bus.g13) n_g13++;
      if (bus.c1) n_c1++;
      if (bus.c21) n_c21++;
      if (bus.g2_pos) begin
        n_g2++;
        g2_last = int'(bus.digit);
      end
      if (bus.g3_pos) n_g3++;
      if (bus.g6_pos) n_g6++;
      if (bus.da_m) begin
        n_da++;
        da_dig = int'(bus.digit);
      end
      if (!bus.g11_neg) n_g11lo++;
      if (saw_done) begin
        after_busy = int'(bus.busy);
        break;
      end
      if (bus.done) begin
        saw_done = 1;
        n_done++;
        done_dig = int'(bus.digit);
      end
      if (!bus.busy) break;
      if (second && bus.g13 && !sent2) begin
        bus.start = 1'b1;
        bus.order = 5'd31;
        sent2 = 1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, saw_done, 1);
  endtask

  task automatic expect_run(input string tag,
                            input int e_g12, input int e_g13,
                            input int e_c1, input int e_c21,
                            input int e_g2, input int e_g3,
                            input int e_g6, input int e_da,
                            input int e_lo, input int e_first);
    chk({tag, "_g12"}, n_g12, e_g12);
    chk({tag, "_g13"}, n_g13, e_g13);
    chk({tag, "_c1"}, n_c1, e_c1);
    chk({tag, "_c21"}, n_c21, e_c21);
    chk({tag, "_g2"}, n_g2, e_g2);
    chk({tag, "_g3"}, n_g3, e_g3);
    chk({tag, "_g6"}, n_g6, e_g6);
    chk({tag, "_da"}, n_da, e_da);
    chk({tag, "_g11lo"}, n_g11lo, e_lo);
    chk({tag, "_first_g12"}, first_g12, e_first);
    chk({tag, "_done_n"}, n_done, 1);
    chk({tag, "_done_dig"}, done_dig, WL - 1);
`ifdef MCAND_SINGLE_STEP_EN
    chk({tag, "_hold_busy"}, after_busy, 1);
`else
    chk({tag, "_idle_busy"}, after_busy, 0);
`endif
  endtask

`ifdef MCAND_SINGLE_STEP_EN
  task automatic release_hold(input string tag);
    chk({tag, "_h_busy"}, bus.busy, 1);
    chk({tag, "_h_g11"}, bus.g11_neg, 1);
    chk({tag, "_h_g12"}, bus.g12, 0);
    chk({tag, "_h_g13"}, bus.g13, 0);
    chk({tag, "_h_c21"}, bus.c21, 0);
    chk({tag, "_h_g3"}, bus.g3_pos, 0);
    chk({tag, "_h_g6"}, bus.g6_pos, 0);
    wait_digit(10);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_digit(WL - 1);
    chk({tag, "_h_busy35"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_h_dig0"}, bus.digit, 0);
    chk({tag, "_h_idle"}, bus.busy, 0);
    bus.start = 1'b1;
    bus.order = 5'd28;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_h_restart"}, bus.busy, 1);
    wait_digit(WL - 1);
    @(negedge clk);
    chk({tag, "_h_restart_g12"}, bus.g12, 1);
    wait_digit(WL - 1);
    while (bus.busy && !bus.done) @(negedge clk);
    @(negedge clk);
    wait_digit(10);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_digit(0);
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.order = 5'd0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_digit", bus.digit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_g11", bus.g11_neg, 0);
    chk("rst_g2neg", bus.g2_neg, 1);
    chk("rst_g12", bus.g12, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_digit", bus.digit, 1);
    chk("idle_g11", bus.g11_neg, 1);

    run("A", 5, 5'd28, 0);
    expect_run("A", 36, 36, 72, 0, 0, 0,
               36, 0, 36, 30);
    chk("A_da_dig", da_dig, -1);
`ifdef MCAND_SINGLE_STEP_EN
    release_hold("A");
`endif

    run("V", 3, 5'd31, 0);
    expect_run("V", 36, 36, 36 * 18, 0, 35,
               36 * 17, 0, 1, 36, 32);
    chk("V_da_dig", da_dig, WL - 1);
    chk("V_g2_last", g2_last, WL - 2);
`ifdef MCAND_SINGLE_STEP_EN
    release_hold("V");
`endif

    run("L", 20, 5'd25, 0);
    expect_run("L", 36, 36, 0, 0, 0, 0,
               0, 0, 72, 15);
`ifdef MCAND_SINGLE_STEP_EN
    release_hold("L");
`endif

    run("B", WL - 1, 5'd28, 1);
    expect_run("B", 36, 36, 72, 0, 0, 0,
               36, 0, 36, 0);
`ifdef MCAND_SINGLE_STEP_EN
    release_hold("B");
`endif

    run("O", 0, 5'd9, 0);
    expect_run("O", 36, 36, 0, 72, 0, 0,
               0, 0, 36, 35);
`ifdef MCAND_SINGLE_STEP_EN
    release_hold("O");
`endif

    wait_digit(0);
    bus.start = 1'b1;
    bus.order = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.g3_pos && int'(bus.digit) == 17) break;
      @(negedge clk);
    end
    chk("R_exec_reached", bus.g3_pos, 1);
    rst_n = 1'b0;
    #1;
    chk("R_digit", bus.digit, 0);
    chk("R_busy", bus.busy, 0);
    chk("R_g3", bus.g3_pos, 0);
    chk("R_c1", bus.c1, 0);
    chk("R_g11", bus.g11_neg, 0);
    chk("R_g2neg", bus.g2_neg, 1);
    repeat (3) @(negedge clk);
    chk("R_hold_digit", bus.digit, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("R_rel_digit", bus.digit, 1);
    chk("R_rel_g11", bus.g11_neg, 1);
    chk("R_rel_busy", bus.busy, 0);
    repeat (80) begin
      @(negedge clk);
      if (bus.g12 || bus.g3_pos) break;
    end
    chk("R_no_resume", bus.g12 | bus.g3_pos, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiplicand_sequencer.md
Name: multiplicand_sequencer

Overview:
- Word-timed gate generator for the Multiplicand Tank and its Main Control stage signals.
- Free-running digit counter marks word boundaries of the 36-digit circulating word.
- Latches an order request, decodes the 5-bit order code, then drives Stage 1, Stage 2 and execute word-times.
- Outputs: g12, g13, c1, c21, g2_pos/g2_neg, g3_pos, g6_pos, g11_neg, da_m, fully aligned to digit 0 of each word.

Parameters:
WORD_LEN, 36, digits per word-time; must match tank length
MULT_WORDS, 17, execute word-times for V and N orders
CW, 6, digit counter width; must satisfy 2^CW >= WORD_LEN

Ports:
clk  input  1  digit clock
rst_n  input  1  asynchronous active-low reset
start  input  1  order request pulse, any digit
order  input  5  order code, sampled with start
busy  output  1  request pending or order in progress
done  output  1  one-digit pulse at final digit of last execute word
digit  output  CW  current digit position, 0..WORD_LEN-1
g12  output  1  Stage 1 of Main Control
g13  output  1  Stage 2 of Main Control
c1  output  1  memory-operand order class: A, S, C, V, N
c21  output  1  O-order
g2_pos  output  1  shifting gate (one-digit delay inserted)
g2_neg  output  1  always ~g2_pos
g3_pos  output  1  multiplicand output gate
g6_pos  output  1  multiplicand shift for A, S, C
g11_neg  output  1  inverse clear: 1 recirculate/admit, 0 clear
da_m  output  1  multiplicand sign-test pulse

Behaviour:
- Reset (async, rst_n=0): digit=0, state IDLE, pending=0, order register=0. busy, done, g12, g13, c1, c21, g2_pos, g3_pos, g6_pos, g11_neg and da_m are 0; g2_neg=1. The tank clears while reset is held.
- Reset deasserted mid-order aborts the order. No partial gates remain after reset.
- Digit counter increments every clk and wraps WORD_LEN-1 -> 0. It never stalls.
- Decode:
  - A=28, S=12, C=30: c1=1, short execute.
  - V=31, N=22: c1=1, multiply execute.
  - O=9: c21=1.
  - All other codes: neither c1 nor c21.
- c1 and c21 are registered from the latched order. They stay valid from STAGE2 through the end of EXEC.
- Request handling:
  - start while IDLE and not pending: set pending, latch order; busy=1 next cycle.
  - start while busy: ignored, order register unchanged.
  - start at digit WORD_LEN-1 while IDLE: STAGE1 begins at the following digit 0.
- State machine. All transitions occur on the clk edge where digit wraps WORD_LEN-1 -> 0.
  - IDLE: g11_neg=1 (recirculate). If pending: go to STAGE1 and clear pending.
  - STAGE1 (1 word): g12=1, g11_neg=0.
  - STAGE2 (1 word): g13=1. g11_neg=1 if c1 or c21, else 0.
  - EXEC: g11_neg=1 for every execute word. Execute length is MULT_WORDS words for V and N, otherwise 1 word.
  - In EXEC: A, S, C give g6_pos=1 for the whole word.
  - In EXEC: V, N give g3_pos=1 in every execute word. V, N also give da_m=1 at digit WORD_LEN-1 of execute word 0 only.
  - In EXEC: g2_pos=1 at digits 0..WORD_LEN-2 of execute word 0 for V and N only. It is 0 at digit WORD_LEN-1 and in later words.
  - Exit from EXEC: done=1 at digit WORD_LEN-1 of the last execute word; then IDLE, or HOLD when the optional feature below is enabled.
- Execute word counter is ceil(log2(MULT_WORDS+1)) bits. It resets to 0 on EXEC entry. Counter wrap inside EXEC is impossible by construction.
- All gate outputs are registered. No output glitches within a digit.

Optional Feature:
- Macro: MCAND_SINGLE_STEP_EN.
- When defined, adds port step (input, 1 bit) and state HOLD.
- After EXEC, the sequencer enters HOLD instead of IDLE, with busy=1, g11_neg=1 (recirculate) and all other gates 0.
- A step pulse in HOLD returns to IDLE at the next word boundary. start is ignored in HOLD.
- When undefined, there is no step port and no HOLD state; EXEC returns directly to IDLE.

Test Plan:
- Reset: assert rst_n=0 at digit 17 mid-EXEC of a V order -> all gates 0, g2_neg=1, digit=0 immediately. After release, IDLE with g11_neg=1.
- A order: start with order=28 at digit 5 -> STAGE1 digits 0..35 (g12=1, g11_neg=0), then STAGE2 (g13=1, c1=1, g11_neg=1), then one EXEC word with g6_pos=1. done at digit 35; busy=0 next cycle.
- V order: order=31 -> 17 EXEC words with g3_pos=1. da_m pulses exactly once at word 0 digit 35. g2_pos=1 at word 0 digits 0..34 only.
- Non-memory order: order=25 (L) -> STAGE2 with g11_neg=0, c1=c21=0; g6_pos and g3_pos never asserted.
- Boundary: start at digit 35 in IDLE -> g12 rises at the next digit 0. A second start during STAGE2 with order=31 is ignored; behaviour stays that of the first order.
- With MCAND_SINGLE_STEP_EN: O order (order=9) -> HOLD after done, busy=1, g11_neg=1. step at digit 10 -> IDLE at the next digit 0.
